// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-side encodings and default widths.
package mips_pkg;
  localparam int ADDR_W_DEF   = 16;
  localparam int INSTR_W_DEF  = 16;
  localparam int PC_STEP_DEF  = 2;
  localparam int RESET_PC_DEF = 0;
  localparam int BR_IMM_W_DEF = 6;
  localparam int J_IMM_W_DEF  = 12;
  typedef enum logic [1:0] {
    REDIR_BR  = 2'b00,
    REDIR_J   = 2'b01,
    REDIR_REG = 2'b10,
    REDIR_RSV = 2'b11
  } redir_t;
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational sequential/redirect next-PC selection with alignment check.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PC_STEP  = PC_STEP_DEF,
  parameter int BR_IMM_W = BR_IMM_W_DEF,
  parameter int J_IMM_W  = J_IMM_W_DEF
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic               redir_valid,
  input  logic [1:0]         redir_type,
  input  logic [ADDR_W-1:0]  redir_base,
  input  logic [J_IMM_W-1:0] redir_imm,
  input  logic [ADDR_W-1:0]  redir_reg,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               take,
  output logic               misaligned
);
  localparam int SH = $clog2(PC_STEP);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(PC_STEP - 1);
  // Bits of the jump target supplied by the immediate and the implicit zero shift.
  localparam logic [ADDR_W-1:0] JMASK = ADDR_W'((64'd1 << (J_IMM_W + SH)) - 64'd1);
  logic [ADDR_W-1:0] seq, br_off, tgt;
  always_comb begin
    seq        = redir_base + STEP;
    br_off     = {{(ADDR_W-BR_IMM_W){redir_imm[BR_IMM_W-1]}}, redir_imm[BR_IMM_W-1:0]} << SH;
    tgt        = redir_type == REDIR_BR ? seq + br_off :
                 redir_type == REDIR_J  ? (seq & ~JMASK) | (ADDR_W'(redir_imm) << SH) :
                 redir_reg;
    take       = redir_valid && redir_type != REDIR_RSV;
    misaligned = take && (tgt & ALIGN) != '0;
    next_pc    = take ? tgt : pc + STEP;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, decode-facing fetch register and RUN/HALTED control.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int PC_STEP  = PC_STEP_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int BR_IMM_W = BR_IMM_W_DEF,
  parameter int J_IMM_W  = J_IMM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               redir_valid,
  input  logic [1:0]         redir_type,
  input  logic [ADDR_W-1:0]  redir_base,
  input  logic [J_IMM_W-1:0] redir_imm,
  input  logic [ADDR_W-1:0]  redir_reg,
  input  logic               halt_req,
  output logic               halted,
  output logic               misalign_err
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, dec_pc_q, dec_pc_d, next_pc;
  logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
  logic               dec_valid_q, dec_valid_d, err_q, err_d, take, misaligned;
  next_pc_calc #(
    .ADDR_W(ADDR_W), .PC_STEP(PC_STEP), .BR_IMM_W(BR_IMM_W), .J_IMM_W(J_IMM_W)
  ) u_next_pc (
    .pc(pc_q), .redir_valid(redir_valid), .redir_type(redir_type),
    .redir_base(redir_base), .redir_imm(redir_imm), .redir_reg(redir_reg),
    .next_pc(next_pc), .take(take), .misaligned(misaligned)
  );
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    err_d       = err_q;
    if (state_q == ST_HALTED) begin
      dec_valid_d = dec_valid_q && !dec_ready;
    end else if (take) begin
      dec_valid_d = 1'b0;
      pc_d        = misaligned ? pc_q : next_pc;
      err_d       = err_q || misaligned;
      state_d     = (misaligned || halt_req) ? ST_HALTED : ST_RUN;
    end else if (halt_req) begin
      dec_valid_d = dec_valid_q && !dec_ready;
      state_d     = ST_HALTED;
    end else if (!dec_valid_q || dec_ready) begin
      dec_valid_d = 1'b1;
      dec_instr_d = imem_rdata;
      dec_pc_d    = pc_q;
      pc_d        = next_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= ADDR_W'(RESET_PC);
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      err_q       <= err_d;
    end
  end
  assign imem_addr    = pc_q;
  assign dec_valid    = dec_valid_q;
  assign dec_instr    = dec_instr_q;
  assign dec_pc       = dec_pc_q;
  assign halted       = state_q == ST_HALTED;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table plus hand sequences for halt, misalign and reset.
module tb_pc_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] imem_addr, imem_rdata, dec_instr, dec_pc, redir_base, redir_reg;
  logic        dec_valid, dec_ready, redir_valid, halt_req, halted, misalign_err;
  logic [1:0]  redir_type;
  logic [11:0] redir_imm;
  int          total = 0, bad = 0;

  typedef struct {
    logic        rdy, rv, halt, edv, ehalt, eerr;
    logic [1:0]  rt;
    logic [15:0] base, rreg, edpc, eaddr;
    logic [11:0] imm;
  } vec_t;
  vec_t v[17];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1357;
  endfunction
  assign imem_rdata = mem(imem_addr);

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .redir_valid(redir_valid), .redir_type(redir_type), .redir_base(redir_base),
    .redir_imm(redir_imm), .redir_reg(redir_reg), .halt_req(halt_req),
    .halted(halted), .misalign_err(misalign_err)
  );

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [1:0] rt,
                              input logic [15:0] base, input logic [11:0] imm,
                              input logic [15:0] rreg, input logic halt, input logic edv,
                              input logic [15:0] edpc, input logic [15:0] eaddr,
                              input logic ehalt, input logic eerr);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rt = rt; r.base = base; r.imm = imm; r.rreg = rreg;
    r.halt = halt; r.edv = edv; r.edpc = edpc; r.eaddr = eaddr; r.ehalt = ehalt; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [1:0] rt,
                       input logic [15:0] rreg, input logic halt);
    dec_ready = rdy; redir_valid = rv; redir_type = rt; redir_reg = rreg; halt_req = halt;
  endtask

  task automatic expect_state(input string tag, input logic edv, input logic [15:0] edpc,
                              input logic [15:0] eaddr, input logic ehalt, input logic eerr);
    chk({tag, ".valid"}, 32'(dec_valid), 32'(edv));
    chk({tag, ".dec_pc"}, 32'(dec_pc), 32'(edpc));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(eaddr));
    chk({tag, ".halted"}, 32'(halted), 32'(ehalt));
    chk({tag, ".err"}, 32'(misalign_err), 32'(eerr));
    if (edv) chk({tag, ".instr"}, 32'(dec_instr), 32'(mem(edpc)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    redir_base = '0; redir_imm = '0;
    v[0]  = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0000,16'h0002,0,0);
    v[1]  = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0002,16'h0004,0,0);
    v[2]  = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0004,16'h0006,0,0);
    v[3]  = mk(0,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0004,16'h0006,0,0);
    v[4]  = mk(0,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0004,16'h0006,0,0);
    v[5]  = mk(0,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0004,16'h0006,0,0);
    v[6]  = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0006,16'h0008,0,0);
    v[7]  = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0008,16'h000A,0,0);
    // branch 8+2-4 = 6, one bubble then dec_pc 6
    v[8]  = mk(1,1,2'b00,16'h0008,12'h03E,16'h0000,0, 0,16'h0008,16'h0006,0,0);
    v[9]  = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0006,16'h0008,0,0);
    // jump from 0x1234: region bits [15:13] of 0x1236 are 0 -> 0x000A; flushes despite stall
    v[10] = mk(0,1,2'b01,16'h1234,12'h005,16'h0000,0, 0,16'h0006,16'h000A,0,0);
    v[11] = mk(0,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h000A,16'h000C,0,0);
    // jump from 0xF234: region bits 111 -> 0xE00A
    v[12] = mk(1,1,2'b01,16'hF234,12'h005,16'h0000,0, 0,16'h000A,16'hE00A,0,0);
    v[13] = mk(1,1,2'b11,16'h0000,12'h000,16'h0040,0, 1,16'hE00A,16'hE00C,0,0);
    v[14] = mk(1,1,2'b10,16'h0000,12'h000,16'hFFFE,0, 0,16'hE00A,16'hFFFE,0,0);
    v[15] = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'hFFFE,16'h0000,0,0);
    v[16] = mk(1,0,2'b00,16'h0000,12'h000,16'h0000,0, 1,16'h0000,16'h0002,0,0);

    do_reset();
    expect_state("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset.instr", 32'(dec_instr), 32'h0);
    for (int i = 0; i < 17; i++) begin
      drive(v[i].rdy, v[i].rv, v[i].rt, v[i].rreg, v[i].halt);
      redir_base = v[i].base; redir_imm = v[i].imm;
      step();
      expect_state($sformatf("vec%0d", i), v[i].edv, v[i].edpc, v[i].eaddr, v[i].ehalt, v[i].eerr);
    end

    // misaligned register target: halt, flush, PC stays 2, later redirects ignored
    drive(1'b1, 1'b1, 2'b10, 16'h0031, 1'b0);
    step();
    expect_state("mis", 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2'b10, 16'h0040, 1'b0);
    step();
    expect_state("mis_ign", 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b1);

    // halt while the decode register is stalled
    do_reset();
    expect_state("rst2", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    step();
    expect_state("pre_halt", 1'b1, 16'h0002, 16'h0004, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 16'h0, 1'b1);
    step();
    expect_state("halt", 1'b1, 16'h0002, 16'h0004, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    expect_state("halt_hold", 1'b1, 16'h0002, 16'h0004, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    expect_state("halt_drain", 1'b0, 16'h0002, 16'h0004, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 16'h0100, 1'b0);
    step();
    expect_state("halt_redir", 1'b0, 16'h0002, 16'h0004, 1'b1, 1'b0);

    // simultaneous redirect and halt: target taken, then frozen
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    expect_state("pre_rh", 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 16'h0200, 1'b1);
    step();
    expect_state("redir_halt", 1'b0, 16'h0000, 16'h0200, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    expect_state("rh_frozen", 1'b0, 16'h0000, 16'h0200, 1'b1, 1'b0);

    // reset in the middle of a stall
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    step();
    drive(1'b0, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    expect_state("stall", 1'b1, 16'h0002, 16'h0004, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_state("mid_rst", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("mid_rst.instr", 32'(dec_instr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
